huc_mem_seq: RTL and testbench
==============================

Name: huc_mem_seq

Overview:
- Downstream of the HuCard mapper stage: consumes its rom and ram memory-control bundles and sequences them onto the shared external asynchronous cartridge memory bus.
- Turns the CPU-strobed requests into timed SRAM/PSRAM cycles with programmable wait states.
- Returns latched read data on rom_dato/ram_dato, which feed back to the mapper as its rom/ram read data.

Parameters:
- RD_WAIT, 3, cycles mem_oe_n held low before read data is sampled (1..15)
- WR_WAIT, 3, cycles mem_we_n held low (1..15)
- AW, 24, address width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rom_addr  in  AW  rom request address
- rom_dati  in  8  rom write data
- rom_ce  in  1  rom region select
- rom_ce2  in  1  CPU cycle strobe (rom bundle)
- rom_oe  in  1  rom read request
- rom_we  in  1  rom write request
- ram_addr  in  AW  ram request address
- ram_dati  in  8  ram write data
- ram_ce  in  1  ram region select
- ram_ce2  in  1  CPU cycle strobe (ram bundle)
- ram_oe  in  1  ram read request
- ram_we  in  1  ram write request
- mem_addr  out  AW  external address
- mem_dq_i  in  8  external data in
- mem_dq_o  out  8  external data out
- mem_dq_oe  out  1  external data driver enable
- mem_ce_n  out  2  chip selects, [0]=rom, [1]=ram
- mem_oe_n  out  1  external output enable
- mem_we_n  out  1  external write enable
- rom_dato  out  8  last rom read data
- ram_dato  out  8  last ram read data
- busy  out  1  sequencer not IDLE

Behaviour:
- Reset (async, rst_n low): mem_ce_n=2'b11, mem_oe_n=1, mem_we_n=1, mem_dq_oe=0, mem_dq_o=0, mem_addr=0, rom_dato=ram_dato=8'hFF, busy=0, state=IDLE, counter=0.
- Strobes are deasserted the instant reset asserts, including mid-cycle.
- Start condition: rising edge of (rom_ce2|ram_ce2), detected against a registered copy of that OR. The strobe is already in the clk domain.
- Start is sampled only in IDLE; edges in any other state are ignored.
- Select at start: rom if rom_ce=1, else ram if ram_ce=1, else no cycle (state goes to HOLD). If both are set, rom wins.
- Latched at start: addr, dati, oe, we, sel.
- Request classification: we=1 means write (takes priority over oe); oe=1 alone means read; neither means HOLD with no bus activity.
- States:
  - IDLE: wait for the start condition.
  - SETUP (1 cycle): drive mem_addr and the selected mem_ce_n bit low. For a write, also mem_dq_o=dati and mem_dq_oe=1.
  - RD: mem_oe_n=0 for RD_WAIT cycles. On the final cycle, mem_dq_i is registered into rom_dato or ram_dato per sel. Next: REC.
  - WR: mem_we_n=0 for WR_WAIT cycles; addr and data stay stable. Next: REC.
  - REC (1 cycle): mem_oe_n=mem_we_n=1. Addr, ce_n and dq_oe are held for this cycle. Next: HOLD.
  - HOLD: mem_ce_n=11, mem_dq_oe=0. Return to IDLE once (rom_ce2|ram_ce2)=0.
- Latency: read data is valid on the selected dato output 2+RD_WAIT clk cycles after the start-edge cycle, and holds until the next read of the same region.
- A CPU strobe that falls before the access finishes does not abort it; the cycle completes and HOLD exits immediately.
- The wait counter is 4 bits and reloads at entry to RD/WR. Parameter value 0 is illegal (elaboration assertion).
- The rom and ram dato registers are independent; a ram read never alters rom_dato.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: HUC_MEM_WRPROT_EN.
- Defined: a rom-selected request with we=1 and oe=0 is treated as no-op (no mem_we_n pulse, state goes to HOLD). A rom request with we=1 and oe=1 is executed as a read.
- Undefined: rom writes pass through to mem_we_n like ram writes.

Test Plan:
- Rom read: rom_ce=1, rom_oe=1, rom_addr=24'h7F0123, mem_dq_i=8'hA5, ce2 rising edge -> mem_ce_n=2'b10, mem_oe_n low 3 cycles, rom_dato=8'hA5 at cycle 5, ram_dato stays 8'hFF.
- Ram write: ram_ce=1, ram_we=1, ram_dati=8'h3C, addr=24'h000010 -> mem_ce_n=2'b01, mem_dq_o=8'h3C with mem_dq_oe=1 from SETUP through REC, mem_we_n low exactly 3 cycles.
- Strobe drops early: ce2 pulse of 1 cycle on a rom read -> full RD_WAIT access completes, busy falls 1 cycle after REC.
- Both ce set on a read -> rom chip select only; mem_ce_n[1] stays 1 throughout.
- Reset asserted mid-WR -> mem_we_n=1, mem_ce_n=11, mem_dq_oe=0 asynchronously; after release, state=IDLE and a new ce2 edge starts a clean cycle.
- HUC_MEM_WRPROT_EN defined, rom_we=1, rom_oe=0 -> mem_we_n never low, busy high until ce2 falls. Without the macro, a 3-cycle mem_we_n pulse occurs.

Source files
------------

// File: rtl/huc_mem_seq.sv
// HuCard external memory sequencer: turns mapper rom/ram strobes into timed async SRAM cycles.
// Optional: define HUC_MEM_WRPROT_EN to drop rom-region writes (rom we+oe becomes a plain read).
module huc_mem_seq #(
  parameter int RD_WAIT = 3,
  parameter int WR_WAIT = 3,
  parameter int AW      = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_dati,
  input  logic          rom_ce,
  input  logic          rom_ce2,
  input  logic          rom_oe,
  input  logic          rom_we,
  input  logic [AW-1:0] ram_addr,
  input  logic [7:0]    ram_dati,
  input  logic          ram_ce,
  input  logic          ram_ce2,
  input  logic          ram_oe,
  input  logic          ram_we,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_dq_i,
  output logic [7:0]    mem_dq_o,
  output logic          mem_dq_oe,
  output logic [1:0]    mem_ce_n,
  output logic          mem_oe_n,
  output logic          mem_we_n,
  output logic [7:0]    rom_dato,
  output logic [7:0]    ram_dato,
  output logic          busy
);

  generate
    if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
      $error("huc_mem_seq: RD_WAIT must be in 1..15");
    end
    if (WR_WAIT < 1 || WR_WAIT > 15) begin : g_bad_wr_wait
      $error("huc_mem_seq: WR_WAIT must be in 1..15");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RD,
    WR,
    REC,
    HOLD
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          ce2_or;
  logic          ce2_q;
  logic          start;
  logic          req_we;
  logic          req_oe;
  logic          eff_we;
  logic          eff_rd;
  logic          has_cycle;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_q;
  logic [7:0]    dati_q;
  logic          sel_ram_q;
  logic          wr_q;
  logic          active;

  assign ce2_or = rom_ce2 | ram_ce2;
  assign start  = (state == IDLE) && ce2_or && !ce2_q;

  // Request classification from the bundle that wins selection (rom over ram).
  always_comb begin
    req_we = rom_ce ? rom_we : ram_we;
    req_oe = rom_ce ? rom_oe : ram_oe;
`ifdef HUC_MEM_WRPROT_EN
    eff_we = rom_ce ? 1'b0 : req_we;
`else
    eff_we = req_we;
`endif
    eff_rd    = req_oe && !eff_we;
    has_cycle = (rom_ce || ram_ce) && (eff_we || eff_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = has_cycle ? SETUP : HOLD;
      SETUP:   next_state = wr_q ? WR : RD;
      RD:      if (cnt == 4'd1) next_state = REC;
      WR:      if (cnt == 4'd1) next_state = REC;
      REC:     next_state = HOLD;
      HOLD:    if (!ce2_or) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, wait counter and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce2_q     <= 1'b0;
      cnt       <= 4'd0;
      addr_q    <= '0;
      dati_q    <= 8'h00;
      sel_ram_q <= 1'b0;
      wr_q      <= 1'b0;
      rom_dato  <= 8'hFF;
      ram_dato  <= 8'hFF;
    end else begin
      ce2_q <= ce2_or;
      if (start && has_cycle) begin
        addr_q    <= rom_ce ? rom_addr : ram_addr;
        dati_q    <= rom_ce ? rom_dati : ram_dati;
        sel_ram_q <= !rom_ce;
        wr_q      <= eff_we;
      end
      if (state == SETUP) begin
        cnt <= wr_q ? 4'(WR_WAIT) : 4'(RD_WAIT);
      end else if ((state == RD || state == WR) && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state == RD && cnt == 4'd1) begin
        if (sel_ram_q) ram_dato <= mem_dq_i;
        else           rom_dato <= mem_dq_i;
      end
    end
  end

  // Strobes decode straight from state so reset deasserts them immediately.
  always_comb begin
    active    = (state == SETUP) || (state == RD) || (state == WR) || (state == REC);
    mem_addr  = addr_q;
    mem_dq_o  = dati_q;
    mem_ce_n  = active ? (sel_ram_q ? 2'b01 : 2'b10) : 2'b11;
    mem_oe_n  = (state != RD);
    mem_we_n  = (state != WR);
    mem_dq_oe = active && wr_q;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_huc_mem_seq.sv
// Directed self-checking bench for huc_mem_seq (default RD_WAIT=WR_WAIT=3, AW=24).
module tb_huc_mem_seq;

  logic        clk;
  logic        rst_n;
  logic [23:0] rom_addr;
  logic [7:0]  rom_dati;
  logic        rom_ce;
  logic        rom_ce2;
  logic        rom_oe;
  logic        rom_we;
  logic [23:0] ram_addr;
  logic [7:0]  ram_dati;
  logic        ram_ce;
  logic        ram_ce2;
  logic        ram_oe;
  logic        ram_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_dq_i;
  logic [7:0]  mem_dq_o;
  logic        mem_dq_oe;
  logic [1:0]  mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic [7:0]  rom_dato;
  logic [7:0]  ram_dato;
  logic        busy;

  int total = 0;
  int bad   = 0;

  huc_mem_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rom_addr  (rom_addr),
    .rom_dati  (rom_dati),
    .rom_ce    (rom_ce),
    .rom_ce2   (rom_ce2),
    .rom_oe    (rom_oe),
    .rom_we    (rom_we),
    .ram_addr  (ram_addr),
    .ram_dati  (ram_dati),
    .ram_ce    (ram_ce),
    .ram_ce2   (ram_ce2),
    .ram_oe    (ram_oe),
    .ram_we    (ram_we),
    .mem_addr  (mem_addr),
    .mem_dq_i  (mem_dq_i),
    .mem_dq_o  (mem_dq_o),
    .mem_dq_oe (mem_dq_oe),
    .mem_ce_n  (mem_ce_n),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n),
    .rom_dato  (rom_dato),
    .ram_dato  (ram_dato),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    rom_ce = 0; rom_oe = 0; rom_we = 0; rom_ce2 = 0;
    ram_ce = 0; ram_oe = 0; ram_we = 0; ram_ce2 = 0;
  endtask

  initial begin
    clear_req();
    rom_addr = '0; rom_dati = '0; ram_addr = '0; ram_dati = '0;
    mem_dq_i = 8'h00;
    rst_n = 1'b0;
    #23;
    check_output("rst_ce_n", 32'(mem_ce_n), 32'h3);
    check_output("rst_oe_n", 32'(mem_oe_n), 32'h1);
    check_output("rst_we_n", 32'(mem_we_n), 32'h1);
    check_output("rst_dq_oe", 32'(mem_dq_oe), 32'h0);
    check_output("rst_dq_o", 32'(mem_dq_o), 32'h0);
    check_output("rst_addr", 32'(mem_addr), 32'h0);
    check_output("rst_rom_dato", 32'(rom_dato), 32'hFF);
    check_output("rst_ram_dato", 32'(ram_dato), 32'hFF);
    check_output("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();
    tick();

    $display("[TB] rom read");
    rom_ce = 1; rom_oe = 1; rom_addr = 24'h7F0123; mem_dq_i = 8'hA5; rom_ce2 = 1;
    tick();
    check_output("rd_setup_ce_n", 32'(mem_ce_n), 32'h2);
    check_output("rd_setup_oe_n", 32'(mem_oe_n), 32'h1);
    check_output("rd_setup_addr", 32'(mem_addr), 32'h7F0123);
    check_output("rd_setup_busy", 32'(busy), 32'h1);
    check_output("rd_setup_dq_oe", 32'(mem_dq_oe), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("rd_wait_oe_n", 32'(mem_oe_n), 32'h0);
      check_output("rd_wait_ce_n", 32'(mem_ce_n), 32'h2);
      check_output("rd_wait_dato", 32'(rom_dato), 32'hFF);
    end
    tick();
    check_output("rd_rec_oe_n", 32'(mem_oe_n), 32'h1);
    check_output("rd_rec_ce_n", 32'(mem_ce_n), 32'h2);
    check_output("rd_rec_rom_dato", 32'(rom_dato), 32'hA5);
    check_output("rd_rec_ram_dato", 32'(ram_dato), 32'hFF);
    mem_dq_i = 8'h00;
    rom_ce2 = 0;
    tick();
    check_output("rd_hold_ce_n", 32'(mem_ce_n), 32'h3);
    check_output("rd_hold_busy", 32'(busy), 32'h1);
    tick();
    check_output("rd_idle_busy", 32'(busy), 32'h0);
    check_output("rd_dato_held", 32'(rom_dato), 32'hA5);
    clear_req();

    $display("[TB] ram write");
    ram_ce = 1; ram_we = 1; ram_dati = 8'h3C; ram_addr = 24'h000010; mem_dq_i = 8'h99; ram_ce2 = 1;
    tick();
    check_output("wr_setup_ce_n", 32'(mem_ce_n), 32'h1);
    check_output("wr_setup_dq_oe", 32'(mem_dq_oe), 32'h1);
    check_output("wr_setup_dq_o", 32'(mem_dq_o), 32'h3C);
    check_output("wr_setup_we_n", 32'(mem_we_n), 32'h1);
    check_output("wr_setup_addr", 32'(mem_addr), 32'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("wr_pulse_we_n", 32'(mem_we_n), 32'h0);
      check_output("wr_pulse_dq_oe", 32'(mem_dq_oe), 32'h1);
      check_output("wr_pulse_oe_n", 32'(mem_oe_n), 32'h1);
    end
    tick();
    check_output("wr_rec_we_n", 32'(mem_we_n), 32'h1);
    check_output("wr_rec_dq_oe", 32'(mem_dq_oe), 32'h1);
    check_output("wr_rec_ce_n", 32'(mem_ce_n), 32'h1);
    ram_ce2 = 0;
    tick();
    check_output("wr_hold_dq_oe", 32'(mem_dq_oe), 32'h0);
    check_output("wr_hold_ce_n", 32'(mem_ce_n), 32'h3);
    tick();
    check_output("wr_idle_busy", 32'(busy), 32'h0);
    check_output("wr_ram_dato", 32'(ram_dato), 32'hFF);
    clear_req();

    $display("[TB] strobe drops early");
    rom_ce = 1; rom_oe = 1; rom_addr = 24'h000200; mem_dq_i = 8'h5A; rom_ce2 = 1;
    tick();
    rom_ce2 = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("early_oe_n", 32'(mem_oe_n), 32'h0);
    end
    tick();
    check_output("early_dato", 32'(rom_dato), 32'h5A);
    check_output("early_rec_busy", 32'(busy), 32'h1);
    tick();
    check_output("early_hold_busy", 32'(busy), 32'h1);
    tick();
    check_output("early_idle_busy", 32'(busy), 32'h0);
    clear_req();

    $display("[TB] both ce on read");
    rom_ce = 1; rom_oe = 1; ram_ce = 1; ram_oe = 1; rom_addr = 24'h000300; ram_addr = 24'h000400;
    mem_dq_i = 8'h77; ram_ce2 = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("both_ce_n", 32'(mem_ce_n), 32'h2);
    end
    check_output("both_rom_dato", 32'(rom_dato), 32'h77);
    check_output("both_ram_dato", 32'(ram_dato), 32'hFF);
    check_output("both_addr", 32'(mem_addr), 32'h300);
    clear_req();
    tick();
    tick();
    check_output("both_idle", 32'(busy), 32'h0);

    $display("[TB] reset mid write");
    ram_ce = 1; ram_we = 1; ram_dati = 8'h81; ram_addr = 24'h000020; ram_ce2 = 1;
    tick();
    tick();
    check_output("mid_we_n_low", 32'(mem_we_n), 32'h0);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_we_n", 32'(mem_we_n), 32'h1);
    check_output("mid_rst_ce_n", 32'(mem_ce_n), 32'h3);
    check_output("mid_rst_dq_oe", 32'(mem_dq_oe), 32'h0);
    check_output("mid_rst_busy", 32'(busy), 32'h0);
    check_output("mid_rst_rom_dato", 32'(rom_dato), 32'hFF);
    clear_req();
    tick();
    rst_n = 1'b1;
    tick();
    check_output("post_rst_busy", 32'(busy), 32'h0);
    check_output("post_rst_addr", 32'(mem_addr), 32'h0);
    ram_ce = 1; ram_oe = 1; ram_addr = 24'h000030; mem_dq_i = 8'hC3; ram_ce2 = 1;
    tick();
    check_output("post_setup_ce_n", 32'(mem_ce_n), 32'h1);
    tick();
    tick();
    tick();
    check_output("post_rd_ram_dato", 32'(ram_dato), 32'hFF);
    tick();
    check_output("post_ram_dato", 32'(ram_dato), 32'hC3);
    check_output("post_rom_dato", 32'(rom_dato), 32'hFF);
    clear_req();
    tick();
    tick();

    $display("[TB] no region selected");
    rom_oe = 1; rom_ce2 = 1;
    tick();
    check_output("nosel_busy", 32'(busy), 32'h1);
    check_output("nosel_ce_n", 32'(mem_ce_n), 32'h3);
    tick();
    check_output("nosel_hold_busy", 32'(busy), 32'h1);
    rom_ce2 = 0;
    tick();
    check_output("nosel_idle", 32'(busy), 32'h0);
    clear_req();

    $display("[TB] rom write");
    rom_ce = 1; rom_we = 1; rom_oe = 0; rom_dati = 8'h4B; rom_addr = 24'h000500; rom_ce2 = 1;
`ifdef HUC_MEM_WRPROT_EN
    for (int i = 0; i < 6; i++) begin
      tick();
      check_output("prot_we_n", 32'(mem_we_n), 32'h1);
      check_output("prot_busy", 32'(busy), 32'h1);
      check_output("prot_ce_n", 32'(mem_ce_n), 32'h3);
    end
    rom_ce2 = 0;
    tick();
    check_output("prot_idle", 32'(busy), 32'h0);
`else
    tick();
    check_output("romwr_setup_we_n", 32'(mem_we_n), 32'h1);
    check_output("romwr_setup_ce_n", 32'(mem_ce_n), 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("romwr_we_n", 32'(mem_we_n), 32'h0);
      check_output("romwr_dq_o", 32'(mem_dq_o), 32'h4B);
    end
    tick();
    check_output("romwr_rec_we_n", 32'(mem_we_n), 32'h1);
    rom_ce2 = 0;
    tick();
    tick();
    check_output("romwr_idle", 32'(busy), 32'h0);
`endif
    clear_req();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
